bcd_count_ctrl: RTL and testbench
=================================

# bcd_count_ctrl

Controller that sequences the 3-digit BCD counter (hundreds/tens/units, increment-on-enable) and drives its display. It turns run/stop/step/clear commands into single-cycle count enables at a programmable prescaled rate. It can stop at a programmable BCD terminal count or let the counter wrap, and it time-multiplexes the three digits onto one 4-bit display bus. It sits between the user inputs and the counter's enable and clear inputs.

## Interface
- PRESCALE_W, 16, width of tick-period register/prescaler
- SCAN_W, 10, width of free-running display scan divider; digit advances every 2^SCAN_W cycles
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_start  in  1  level, sampled each cycle: IDLE->RUN
- cmd_stop  in  1  RUN->IDLE
- cmd_step  in  1  one enable per asserted cycle while IDLE
- cmd_clear  in  1  clear counter, return to IDLE
- prescale  in  PRESCALE_W  tick period minus 1 (0 = enable every cycle)
- autostop  in  1  1: halt at limit_bcd; 0: free-run with wrap
- limit_bcd  in  12  terminal count {hundreds,tens,units}
- count_bcd  in  12  counter's registered value {hundreds,tens,units}
- cnt_en  out  1  count enable to counter (combinational from registers and count_bcd)
- cnt_clr  out  1  registered one-cycle clear request to counter
- state  out  2  00 IDLE, 01 RUN, 10 DONE
- done  out  1  state==DONE
- wrapped  out  1  registered one-cycle pulse after a 999->000 increment
- digit_sel  out  3  one-hot digit strobe: 001 units, 010 tens, 100 hundreds
- digit_val  out  4  BCD value of the selected digit (combinational mux of count_bcd)

## Operation
- at_limit = autostop & (count_bcd == limit_bcd). A limit with any nibble >9 never matches.
- Command priority: clear > stop > start > step. Only the highest-priority asserted command acts.
- FSM:
  - IDLE: start -> RUN with prescaler=0. step fires cnt_en for that cycle unless at_limit.
  - RUN: prescaler increments each cycle. When prescaler >= prescale:
    - if at_limit: cnt_en=0, -> DONE;
    - else cnt_en=1 and prescaler -> 0.
  - RUN: stop -> IDLE, prescaler -> 0.
  - DONE: start, step and stop are ignored. Only clear (or rst) exits.
  - any state: clear -> IDLE, prescaler -> 0, cnt_clr=1 in the following cycle. No cnt_en in the clear cycle.
- cnt_en is 0 in every cycle not listed above, and always 0 while rst=1.
- wrapped=1 in the cycle after any cycle with cnt_en=1 and count_bcd==12'h999 (autostop=0, or limit beyond 999).
- Prescale may change at any time. The >= compare bounds the next tick to at most one cycle after the new value is reached; the prescaler never wraps.
- Display scan:
  - scan divider free-runs in all states.
  - On all-ones it rolls over and digit_sel rotates 001->010->100->001.
  - digit_val = units/tens/hundreds nibble of count_bcd for the active strobe.

## Timing
- Reset values: state=IDLE, prescaler=0, cnt_en=0, cnt_clr=0, done=0, wrapped=0, scan divider=0, digit_sel=001, digit_val=count_bcd[3:0].
- Start sampled at edge E0: RUN from E0. First cnt_en in the cycle after edge E0+prescale, then every prescale+1 cycles.
- Counter increments on the edge ending a cnt_en cycle, so count_bcd is current in the next cycle. at_limit therefore never overshoots, even with prescale=0.
- DONE is entered on the edge ending the tick cycle in which at_limit held.
- Step: cnt_en in the same cycle cmd_step is high (IDLE only). Holding cmd_step for N cycles gives N enables.
- rst mid-run: next cycle all reset values. No cnt_clr is issued, since the counter has its own reset.

## Test plan
- Reset: hold rst 3 cycles with commands asserted -> cnt_en=0 throughout; after release, state=00, digit_sel=001, cnt_clr=0, wrapped=0.
- Prescaled run: prescale=3, autostop=0, pulse start at cycle 0 -> cnt_en high exactly at cycles 4, 8, 12; stop at cycle 13 -> no further enables, state=00.
- Autostop: prescale=0, limit_bcd=12'h012, autostop=1, counter model at 000, start -> exactly 12 enables, count_bcd=012, state=10, done=1; a later start or step -> no cnt_en.
- Wrap: prescale=0, autostop=0, run 1000 ticks from 000 -> count_bcd=000, wrapped high exactly one cycle, the cycle after the 999 tick.
- Priority: clear+start+step in the same cycle from RUN -> cnt_en=0 that cycle, cnt_clr=1 next cycle, state=00, prescaler restarts at 0 on next start.
- Scan: SCAN_W=2, count_bcd=12'h357 -> digit_sel 001/010/100 each for 4 cycles, digit_val 7/5/3 respectively, pattern repeats.

Source files
------------

// File: rtl/bcd_count_ctrl_if.sv
// bcd_count_ctrl_if: command, counter-link and display signals of the BCD count controller
interface bcd_count_ctrl_if #(parameter int PRESCALE_W = 16);
   logic                  cmd_start;
   logic                  cmd_stop;
   logic                  cmd_step;
   logic                  cmd_clear;
   logic [PRESCALE_W-1:0] prescale;
   logic                  autostop;
   logic [11:0]           limit_bcd;
   logic [11:0]           count_bcd;
   logic                  cnt_en;
   logic                  cnt_clr;
   logic [1:0]            state;
   logic                  done;
   logic                  wrapped;
   logic [2:0]            digit_sel;
   logic [3:0]            digit_val;
   modport master (
      output cmd_start, cmd_stop, cmd_step, cmd_clear, prescale, autostop, limit_bcd, count_bcd,
      input  cnt_en, cnt_clr, state, done, wrapped, digit_sel, digit_val
   );
   modport slave (
      input  cmd_start, cmd_stop, cmd_step, cmd_clear, prescale, autostop, limit_bcd, count_bcd,
      output cnt_en, cnt_clr, state, done, wrapped, digit_sel, digit_val
   );
endinterface

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: run/stop/step/clear sequencer, prescaled enables, terminal-count stop and digit scan for a 3-digit BCD counter
module bcd_count_ctrl #(
   parameter int PRESCALE_W = 16,
   parameter int SCAN_W     = 10
) (
   input  logic           clk,
   input  logic           rst,
   bcd_count_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
   state_t                st, st_nx;
   logic [PRESCALE_W-1:0] pre, pre_nx;
   logic [SCAN_W-1:0]     scan;
   logic [2:0]            sel;
   logic                  clr_q, wrap_q, en;
   logic                  lim_ok, at_limit, due;
   logic                  do_clear, do_stop, do_start, do_step;
   // a limit with a non-decimal nibble can never be reached by a BCD counter
   assign lim_ok   = bus.limit_bcd[11:8] <= 4'd9 && bus.limit_bcd[7:4] <= 4'd9 && bus.limit_bcd[3:0] <= 4'd9;
   assign at_limit = bus.autostop & lim_ok & (bus.count_bcd == bus.limit_bcd);
   assign due      = pre >= bus.prescale;
   assign do_clear = bus.cmd_clear;
   assign do_stop  = ~bus.cmd_clear & bus.cmd_stop;
   assign do_start = ~bus.cmd_clear & ~bus.cmd_stop & bus.cmd_start;
   assign do_step  = ~bus.cmd_clear & ~bus.cmd_stop & ~bus.cmd_start & bus.cmd_step;
   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= IDLE;
         pre    <= '0;
         clr_q  <= 1'b0;
         wrap_q <= 1'b0;
         scan   <= '0;
         sel    <= 3'b001;
      end else begin
         st     <= st_nx;
         pre    <= pre_nx;
         clr_q  <= do_clear;
         wrap_q <= en && bus.count_bcd == 12'h999;
         scan   <= scan + SCAN_W'(1);
         if (&scan) sel <= {sel[1:0], sel[2]};
      end
   end
   always_comb begin
      st_nx  = st;
      pre_nx = pre;
      if (do_clear) begin
         st_nx  = IDLE;
         pre_nx = '0;
      end else begin
         case (st)
            IDLE: if (do_start) begin
               st_nx  = RUN;
               pre_nx = '0;
            end
            RUN: if (do_stop) begin
               st_nx  = IDLE;
               pre_nx = '0;
            end else if (due) begin
               st_nx  = at_limit ? DONE : RUN;
               pre_nx = '0;
            end else begin
               pre_nx = pre + PRESCALE_W'(1);
            end
            DONE: st_nx = DONE;
            default: st_nx = IDLE;
         endcase
      end
   end
   // the clear cycle never enables: do_step already excludes clear, RUN masks it explicitly
   always_comb begin
      en = ~rst & ~at_limit & ((st == IDLE & do_step) | (st == RUN & ~do_clear & ~do_stop & due));
   end
   assign bus.cnt_en    = en;
   assign bus.cnt_clr   = clr_q;
   assign bus.state     = st;
   assign bus.done      = st == DONE;
   assign bus.wrapped   = wrap_q;
   assign bus.digit_sel = sel;
   assign bus.digit_val = sel[0] ? bus.count_bcd[3:0] : sel[1] ? bus.count_bcd[7:4] : bus.count_bcd[11:8];
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb_bcd_count_ctrl: directed and random checks of bcd_count_ctrl against a timestamp-based reference model
module tb_bcd_count_ctrl;
   localparam int PW = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   bcd_count_ctrl_if #(.PRESCALE_W(PW)) bus ();
   bcd_count_ctrl #(.PRESCALE_W(PW), .SCAN_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   int n_cmp = 0, n_bad = 0;
   int count = 0;
   int mode = 0;
   int cyc = 0, ref_cyc = 0, sc = 0;
   bit clr_pend = 0, wrap_pend = 0, known = 0, last_en = 0;
   int en_tot = 0, wrap_tot = 0;
   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction
   function automatic int lim_dec(input logic [11:0] l);
      if (l[11:8] > 9 || l[7:4] > 9 || l[3:0] > 9) return -1;
      return int'(l[11:8]) * 100 + int'(l[7:4]) * 10 + int'(l[3:0]);
   endfunction
   assign bus.count_bcd = to_bcd(count);
   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   // one clock cycle: check outputs against the model, then advance model and counter
   task automatic cyc1();
      bit clr, sta, ste, al, due, e_en, en_obs, clr_obs;
      int idx, nx;
      #1;
      clr  = bus.cmd_clear;
      sta  = !clr && !bus.cmd_stop && bus.cmd_start;
      ste  = !clr && !bus.cmd_stop && !bus.cmd_start && bus.cmd_step;
      al   = bus.autostop && lim_dec(bus.limit_bcd) == count;
      due  = (cyc - ref_cyc) > int'(bus.prescale);
      e_en = !rst && !al && ((mode == 0 && ste) || (mode == 1 && !clr && !bus.cmd_stop && due));
      chk("cnt_en", int'(bus.cnt_en), int'(e_en));
      if (known) begin
         idx = (sc / 4) % 3;
         chk("cnt_clr", int'(bus.cnt_clr), int'(clr_pend));
         chk("state", int'(bus.state), mode);
         chk("done", int'(bus.done), int'(mode == 2));
         chk("wrapped", int'(bus.wrapped), int'(wrap_pend));
         chk("digit_sel", int'(bus.digit_sel), 1 << idx);
         chk("digit_val", int'(bus.digit_val), idx == 0 ? count % 10 : idx == 1 ? (count / 10) % 10 : count / 100);
      end
      en_obs   = bus.cnt_en;
      clr_obs  = bus.cnt_clr;
      last_en  = en_obs;
      en_tot  += int'(en_obs);
      wrap_tot += int'(bus.wrapped);
      if (rst) begin
         mode = 0; clr_pend = 0; wrap_pend = 0; sc = 0; known = 1;
      end else begin
         clr_pend  = clr;
         wrap_pend = e_en && count == 999;
         sc++;
         if (clr) mode = 0;
         else if (mode == 1 && bus.cmd_stop) mode = 0;
         else if (mode == 0 && sta) begin mode = 1; ref_cyc = cyc; end
         else if (mode == 1 && due) begin
            if (al) mode = 2;
            else ref_cyc = cyc;
         end
      end
      nx = rst ? 0 : clr_obs ? 0 : en_obs ? (count + 1) % 1000 : count;
      @(posedge clk);
      cyc++;
      #1;
      count = nx;
      @(negedge clk);
   endtask
   task automatic cmds(input bit c, input bit sp, input bit st, input bit se);
      bus.cmd_clear = c; bus.cmd_stop = sp; bus.cmd_start = st; bus.cmd_step = se;
   endtask
   initial begin
      int base, mask;
      cmds(1, 1, 1, 1);
      bus.prescale = '0; bus.autostop = 0; bus.limit_bcd = 12'h000;
      for (int i = 0; i < 3; i++) cyc1();
      rst = 0;
      cmds(0, 0, 0, 0);
      cyc1();
      chk("rst_state", int'(bus.state), 0);
      chk("rst_sel", int'(bus.digit_sel), 1);
      chk("rst_clr", int'(bus.cnt_clr), 0);
      chk("rst_wrap", int'(bus.wrapped), 0);
      // prescaled run
      bus.prescale = 16'd3;
      cmds(1, 0, 0, 0); cyc1();
      cmds(0, 0, 0, 0); cyc1();
      cmds(0, 0, 1, 0); cyc1();
      cmds(0, 0, 0, 0);
      mask = 0;
      for (int i = 1; i <= 12; i++) begin
         cyc1();
         if (last_en) mask |= 1 << i;
      end
      chk("pre_mask", mask, (1 << 4) | (1 << 8) | (1 << 12));
      cmds(0, 1, 0, 0); cyc1();
      cmds(0, 0, 0, 0);
      base = en_tot;
      for (int i = 0; i < 8; i++) cyc1();
      chk("stop_en", en_tot - base, 0);
      chk("stop_state", int'(bus.state), 0);
      // autostop at 012
      bus.prescale = '0; bus.limit_bcd = 12'h012; bus.autostop = 1;
      cmds(1, 0, 0, 0); cyc1();
      cmds(0, 0, 0, 0); cyc1();
      base = en_tot;
      cmds(0, 0, 1, 0); cyc1();
      cmds(0, 0, 0, 0);
      for (int i = 0; i < 25; i++) cyc1();
      chk("auto_en", en_tot - base, 12);
      chk("auto_cnt", int'(bus.count_bcd), 12'h012);
      chk("auto_state", int'(bus.state), 2);
      chk("auto_done", int'(bus.done), 1);
      base = en_tot;
      cmds(0, 0, 1, 0); cyc1();
      cmds(0, 0, 0, 1); cyc1(); cyc1();
      cmds(0, 0, 0, 0); cyc1();
      chk("done_ignore", en_tot - base, 0);
      // wrap through 999
      bus.autostop = 0;
      cmds(1, 0, 0, 0); cyc1();
      cmds(0, 0, 0, 0); cyc1();
      base = en_tot;
      wrap_tot = 0;
      cmds(0, 0, 1, 0); cyc1();
      cmds(0, 0, 0, 0);
      for (int i = 0; i < 1100 && en_tot - base < 1000; i++) cyc1();
      cmds(0, 1, 0, 0); cyc1();
      cmds(0, 0, 0, 0); cyc1();
      chk("wrap_ticks", en_tot - base, 1000);
      chk("wrap_cnt", int'(bus.count_bcd), 0);
      chk("wrap_pulses", wrap_tot, 1);
      // priority: clear beats start and step from RUN
      bus.prescale = 16'd5;
      cmds(0, 0, 1, 0); cyc1();
      cmds(0, 0, 0, 0); cyc1(); cyc1(); cyc1();
      cmds(1, 0, 1, 1); cyc1();
      chk("prio_en", int'(last_en), 0);
      cmds(0, 0, 0, 0); cyc1();
      chk("prio_clr", int'(last_en), 0);
      chk("prio_state", int'(bus.state), 0);
      cmds(0, 0, 1, 0); cyc1();
      cmds(0, 0, 0, 0);
      mask = 0;
      for (int i = 1; i <= 7; i++) begin
         cyc1();
         if (last_en) mask |= 1 << i;
      end
      chk("prio_restart", mask, 1 << 6);
      cmds(1, 0, 0, 0); cyc1();
      cmds(0, 0, 0, 0);
      // display scan of 357
      count = 357;
      for (int i = 0; i < 24; i++) cyc1();
      // random phase
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         cmds(r < 2, r >= 2 && r < 5, r >= 5 && r < 12, r >= 12 && r < 25);
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 19) == 0) bus.prescale = PW'($urandom_range(0, 6));
         if ($urandom_range(0, 29) == 0) bus.autostop = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 29) == 0) begin
            r = int'($urandom_range(0, 7));
            bus.limit_bcd = r == 0 ? 12'hA05 : r < 5 ? to_bcd((count + int'($urandom_range(0, 15))) % 1000) : to_bcd(int'($urandom_range(0, 999)));
         end
         cyc1();
      end
      rst = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
